// File: rtl/vadd_pkg.sv
// vadd_pkg: shared FSM state encoding and BRAM timing constant for the vector-add controller
package vadd_pkg;
   localparam int RD_LAT = 1;
   typedef enum logic [3:0] {
      IDLE, LOAD_A, LOAD_B, START, WAIT_DONE, RD_ISSUE, RD_WAIT, RD_CAPT, SEND
   } state_t;
endpackage

// File: rtl/stream_out_reg.sv
// stream_out_reg: result stream output register, holds the word steady under backpressure
module stream_out_reg #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  last_in,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   output logic                  m_last
);
   // load a fresh word, otherwise keep data/last and drop valid once accepted
   always_ff @(posedge clk) begin
      if (rst) begin
         m_data  <= '0;
         m_valid <= 1'b0;
         m_last  <= 1'b0;
      end else if (load) begin
         m_data  <= din;
         m_valid <= 1'b1;
         m_last  <= last_in;
      end else if (m_valid && m_ready) begin
         m_valid <= 1'b0;
      end
   end
endmodule

// File: rtl/vadd_stream_ctrl.sv
// vadd_stream_ctrl: loads A/B vectors into BRAM, kicks the compute unit, streams results back out
module vadd_stream_ctrl
   import vadd_pkg::*;
#(
   parameter int ADDR_WIDTH = 13,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [ADDR_WIDTH-1:0] cmd_addr_a,
   input  logic [ADDR_WIDTH-1:0] cmd_addr_b,
   input  logic [ADDR_WIDTH-1:0] cmd_addr_out,
   input  logic [31:0]           cmd_len,
   input  logic [DATA_WIDTH-1:0] s_data,
   input  logic                  s_valid,
   output logic                  s_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  m_last,
   output logic                  cu_start,
   output logic [ADDR_WIDTH-1:0] cu_addr_a,
   output logic [ADDR_WIDTH-1:0] cu_addr_b,
   output logic [ADDR_WIDTH-1:0] cu_addr_out,
   output logic [31:0]           cu_len,
   input  logic                  cu_done,
   output logic [ADDR_WIDTH-1:0] bram_addr_a,
   output logic [DATA_WIDTH-1:0] bram_din_a,
   input  logic [DATA_WIDTH-1:0] bram_dout_a,
   output logic                  bram_en_a,
   output logic                  bram_we_a,
   output logic                  busy
);
   state_t                state, state_n;
   logic [31:0]           idx;
   logic [1:0]            rd_cnt;
   logic                  cmd_hs, s_hs, idx_last;
   logic [ADDR_WIDTH-1:0] wr_base;
   assign cmd_hs   = cmd_valid && cmd_ready;
   assign s_hs     = s_valid && s_ready;
   assign idx_last = idx == cu_len - 32'd1;
   assign busy     = state != IDLE;
   assign wr_base  = state == LOAD_A ? cu_addr_a : cu_addr_b;
   // next-state decode
   always_comb begin
      state_n = state;
      case (state)
         IDLE:      state_n = cmd_hs ? LOAD_A : IDLE;
         LOAD_A:    state_n = cu_len == 32'd0 ? IDLE : (s_hs && idx_last) ? LOAD_B : LOAD_A;
         LOAD_B:    state_n = (s_hs && idx_last) ? START : LOAD_B;
         START:     state_n = WAIT_DONE;
         WAIT_DONE: state_n = cu_done ? RD_ISSUE : WAIT_DONE;
         RD_ISSUE:  state_n = RD_WAIT;
         RD_WAIT:   state_n = rd_cnt <= 2'd1 ? RD_CAPT : RD_WAIT;
         RD_CAPT:   state_n = SEND;
         SEND:      state_n = m_ready ? (m_last ? IDLE : RD_ISSUE) : SEND;
         default:   state_n = IDLE;
      endcase
   end
   // state, command latch, index and registered handshake / BRAM / compute-unit outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         idx         <= '0;
         rd_cnt      <= '0;
         cu_addr_a   <= '0;
         cu_addr_b   <= '0;
         cu_addr_out <= '0;
         cu_len      <= '0;
         cmd_ready   <= 1'b0;
         s_ready     <= 1'b0;
         cu_start    <= 1'b0;
         bram_en_a   <= 1'b0;
         bram_we_a   <= 1'b0;
         bram_addr_a <= '0;
         bram_din_a  <= '0;
      end else begin
         state     <= state_n;
         cmd_ready <= state_n == IDLE;
         s_ready   <= (state_n == LOAD_A || state_n == LOAD_B) && !(cmd_hs && cmd_len == 32'd0);
         cu_start  <= state_n == START;
         bram_en_a <= s_hs || state == RD_ISSUE;
         bram_we_a <= s_hs;
         if (cmd_hs) begin
            cu_addr_a   <= cmd_addr_a;
            cu_addr_b   <= cmd_addr_b;
            cu_addr_out <= cmd_addr_out;
            cu_len      <= cmd_len;
            idx         <= '0;
         end
         if (s_hs) begin
            idx         <= idx_last ? '0 : idx + 32'd1;
            bram_addr_a <= wr_base + idx[ADDR_WIDTH-1:0];
            bram_din_a  <= s_data;
         end
         if (state == WAIT_DONE && cu_done) idx <= '0;
         if (state == RD_ISSUE) begin
            bram_addr_a <= cu_addr_out + idx[ADDR_WIDTH-1:0];
            rd_cnt      <= 2'(RD_LAT);
         end
         if (state == RD_WAIT) rd_cnt <= rd_cnt - 2'd1;
         if (state == SEND && m_ready && !m_last) idx <= idx + 32'd1;
      end
   end
   stream_out_reg #(.DATA_WIDTH(DATA_WIDTH)) u_out (
      .clk     (clk),
      .rst     (rst),
      .load    (state == RD_CAPT),
      .din     (bram_dout_a),
      .last_in (idx_last),
      .m_ready (m_ready),
      .m_data  (m_data),
      .m_valid (m_valid),
      .m_last  (m_last)
   );
endmodule

// File: tb/tb_vadd_stream_ctrl.sv
// tb_vadd_stream_ctrl: directed bench with BRAM and compute-unit models around vadd_stream_ctrl
module tb_vadd_stream_ctrl;
   localparam int AW = 13;
   localparam int DW = 32;
   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cmd_valid = 1'b0, cmd_ready;
   logic [AW-1:0] cmd_addr_a = '0, cmd_addr_b = '0, cmd_addr_out = '0;
   logic [31:0]   cmd_len = '0;
   logic [DW-1:0] s_data = '0;
   logic          s_valid = 1'b0, s_ready;
   logic [DW-1:0] m_data;
   logic          m_valid, m_ready = 1'b1, m_last;
   logic          cu_start, cu_done, model_done = 1'b0, spur = 1'b0;
   logic [AW-1:0] cu_addr_a, cu_addr_b, cu_addr_out;
   logic [31:0]   cu_len;
   logic [AW-1:0] bram_addr_a;
   logic [DW-1:0] bram_din_a, bram_dout_a = '0;
   logic          bram_en_a, bram_we_a, busy;
   logic [DW-1:0] mem [1<<AW];
   logic [AW-1:0] ca, cb, co;
   int            cl, cu_cnt = 0;
   int            n_tests = 0, n_fail = 0;
   int            ncyc = 0, mv_cnt = 0, en_cnt = 0, start_cnt = 0, stall_bad = 0;
   bit            rdy_mode = 1'b0, held = 1'b0;
   logic [DW-1:0] hd;
   logic          hl;
   logic [32:0]   outs [$];
   logic [AW-1:0] wr_addr [$];
   logic [DW-1:0] words [$];
   int            ob, wb, e0, s0, m0;

   always #5 clk = ~clk;
   assign cu_done = model_done | spur;

   vadd_stream_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_addr_a(cmd_addr_a), .cmd_addr_b(cmd_addr_b), .cmd_addr_out(cmd_addr_out), .cmd_len(cmd_len),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
      .cu_start(cu_start), .cu_addr_a(cu_addr_a), .cu_addr_b(cu_addr_b), .cu_addr_out(cu_addr_out),
      .cu_len(cu_len), .cu_done(cu_done),
      .bram_addr_a(bram_addr_a), .bram_din_a(bram_din_a), .bram_dout_a(bram_dout_a),
      .bram_en_a(bram_en_a), .bram_we_a(bram_we_a), .busy(busy)
   );

   // BRAM with one-cycle read latency, plus a compute unit that sums A+B a few cycles after start
   always @(posedge clk) begin
      model_done <= 1'b0;
      if (bram_en_a) begin
         bram_dout_a <= mem[bram_addr_a];
         if (bram_we_a) mem[bram_addr_a] = bram_din_a;
      end
      if (rst) cu_cnt = 0;
      else if (cu_start) begin
         ca = cu_addr_a; cb = cu_addr_b; co = cu_addr_out; cl = cu_len; cu_cnt = 4;
      end else if (cu_cnt > 0) begin
         cu_cnt--;
         if (cu_cnt == 0) begin
            for (int i = 0; i < cl; i++) mem[co + AW'(i)] = mem[ca + AW'(i)] + mem[cb + AW'(i)];
            model_done <= 1'b1;
         end
      end
   end

   // result-side driver and observer: sets m_ready, logs handshakes, writes and stalls
   always @(negedge clk) begin
      ncyc++;
      m_ready = rdy_mode ? (ncyc % 3 == 0) : 1'b1;
      if (m_valid && m_ready) outs.push_back({m_last, m_data});
      if (m_valid) mv_cnt++;
      if (bram_en_a) en_cnt++;
      if (bram_en_a && bram_we_a) wr_addr.push_back(bram_addr_a);
      if (cu_start) start_cnt++;
      if (held && (m_data !== hd || m_last !== hl || !m_valid)) stall_bad++;
      held = m_valid && !m_ready;
      hd = m_data;
      hl = m_last;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic issue(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [AW-1:0] o, input int len);
      int cyc = 0;
      @(negedge clk);
      cmd_addr_a = a; cmd_addr_b = b; cmd_addr_out = o; cmd_len = len; cmd_valid = 1'b1;
      while (!cmd_ready && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      chk("cmd_accept", cmd_ready, 1);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic feed(input bit tog);
      int k = 0, cyc = 0;
      while (k < words.size() && cyc < 200) begin
         @(negedge clk);
         cyc++;
         s_valid = tog ? cyc[0] : 1'b1;
         s_data = words[k];
         if (s_valid && s_ready) k++;
      end
      @(negedge clk);
      s_valid = 1'b0;
      chk("feed_done", k, words.size());
   endtask

   task automatic wait_out(input int n);
      int cyc = 0;
      while ((outs.size() < ob + n || busy) && cyc < 500) begin
         @(negedge clk);
         cyc++;
      end
      chk("out_count", outs.size() - ob, n);
      chk("idle_after", busy, 0);
   endtask

   initial begin
      // reset values
      @(negedge clk);
      @(negedge clk);
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_s_ready", s_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_m", {m_valid, m_last, m_data}, 0);
      chk("rst_bram", {bram_en_a, bram_we_a, bram_addr_a, bram_din_a}, 0);
      chk("rst_cu", {cu_start, cu_len, cu_addr_a}, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("cmd_ready_rise", cmd_ready, 1);

      // basic len=4 vector add
      ob = outs.size(); wb = wr_addr.size(); s0 = start_cnt;
      issue(13'h000, 13'h100, 13'h200, 4);
      chk("t1_cu_len", cu_len, 4);
      chk("t1_cu_out", cu_addr_out, 13'h200);
      chk("t1_busy", busy, 1);
      words = '{1, 2, 3, 4, 10, 20, 30, 40};
      feed(1'b0);
      wait_out(4);
      chk("t1_writes", wr_addr.size() - wb, 8);
      for (int i = 0; i < 4; i++) begin
         chk("t1_wr_a", wr_addr[wb + i], AW'(i));
         chk("t1_wr_b", wr_addr[wb + 4 + i], AW'(13'h100 + i));
      end
      chk("t1_starts", start_cnt - s0, 1);
      chk("t1_out0", outs[ob + 0], {1'b0, 32'd11});
      chk("t1_out1", outs[ob + 1], {1'b0, 32'd22});
      chk("t1_out2", outs[ob + 2], {1'b0, 32'd33});
      chk("t1_out3", outs[ob + 3], {1'b1, 32'd44});

      // zero-length command
      e0 = en_cnt; s0 = start_cnt; m0 = mv_cnt;
      issue(13'h010, 13'h020, 13'h030, 0);
      chk("t2_ready_low", cmd_ready, 0);
      chk("t2_s_ready", s_ready, 0);
      @(negedge clk);
      chk("t2_ready_back", cmd_ready, 1);
      chk("t2_idle", busy, 0);
      repeat (3) @(negedge clk);
      chk("t2_no_bram", en_cnt - e0, 0);
      chk("t2_no_start", start_cnt - s0, 0);
      chk("t2_no_mvalid", mv_cnt - m0, 0);

      // stalls on both streams
      ob = outs.size(); rdy_mode = 1'b1; stall_bad = 0;
      issue(13'h010, 13'h020, 13'h030, 3);
      words = '{5, 6, 7, 100, 200, 300};
      feed(1'b1);
      wait_out(3);
      chk("t3_out0", outs[ob + 0], {1'b0, 32'd105});
      chk("t3_out1", outs[ob + 1], {1'b0, 32'd206});
      chk("t3_out2", outs[ob + 2], {1'b1, 32'd307});
      chk("t3_stable", stall_bad, 0);
      rdy_mode = 1'b0;

      // address wrap
      ob = outs.size(); wb = wr_addr.size();
      issue(13'h1FFE, 13'h040, 13'h050, 3);
      words = '{1, 2, 3, 7, 8, 9};
      feed(1'b0);
      wait_out(3);
      chk("t4_wr0", wr_addr[wb + 0], 13'h1FFE);
      chk("t4_wr1", wr_addr[wb + 1], 13'h1FFF);
      chk("t4_wr2", wr_addr[wb + 2], 13'h0000);
      chk("t4_out0", outs[ob + 0], {1'b0, 32'd8});
      chk("t4_out2", outs[ob + 2], {1'b1, 32'd12});

      // spurious cu_done while loading, then reset while waiting on the compute unit
      s0 = start_cnt; m0 = mv_cnt; ob = outs.size();
      issue(13'h060, 13'h070, 13'h080, 2);
      spur = 1'b1;
      @(negedge clk);
      spur = 1'b0;
      chk("t5_still_loading", s_ready, 1);
      words = '{1, 2, 3, 4};
      feed(1'b0);
      for (int c = 0; c < 50 && start_cnt == s0; c++) @(negedge clk);
      chk("t5_started", start_cnt - s0, 1);
      @(negedge clk);
      rst = 1'b1;
      e0 = en_cnt; s0 = start_cnt;
      @(negedge clk);
      chk("t5_rst_cmd_ready", cmd_ready, 0);
      chk("t5_rst_busy", busy, 0);
      chk("t5_rst_s_ready", s_ready, 0);
      chk("t5_rst_m", {m_valid, m_last, m_data}, 0);
      chk("t5_rst_bram", {bram_en_a, bram_we_a, bram_addr_a, bram_din_a}, 0);
      chk("t5_rst_cu", {cu_start, cu_len, cu_addr_a, cu_addr_b, cu_addr_out}, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (8) @(negedge clk);
      chk("t5_ready_after", cmd_ready, 1);
      chk("t5_no_mvalid", mv_cnt - m0, 0);
      chk("t5_no_outs", outs.size() - ob, 0);
      chk("t5_no_bram", en_cnt - e0, 0);
      chk("t5_no_start", start_cnt - s0, 0);
      ob = outs.size();
      issue(13'h300, 13'h310, 13'h320, 2);
      words = '{3, 4, 5, 6};
      feed(1'b0);
      wait_out(2);
      chk("t5_out0", outs[ob + 0], {1'b0, 32'd8});
      chk("t5_out1", outs[ob + 1], {1'b1, 32'd10});

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/vadd_stream_ctrl.md
VADD_STREAM_CTRL -- requirements
Module: vadd_stream_ctrl

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, default 13, BRAM word-address width; DATA_WIDTH, default 32, vector element width.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset; clock and reset ports are listed first below.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 cmd_valid/cmd_ready  in/out  1/1  command handshake; transfer when both are high.
REQ-006 cmd_addr_a, cmd_addr_b, cmd_addr_out  in  ADDR_WIDTH each  BRAM base addresses for A, B and result.
REQ-007 cmd_len  in  32  element count per vector.
REQ-008 s_data/s_valid/s_ready  in/in/out  DATA_WIDTH/1/1  input stream carrying len A words, then len B words.
REQ-009 m_data/m_valid/m_ready/m_last  out/out/in/out  DATA_WIDTH/1/1/1  result stream; m_last marks the final word.
REQ-010 cu_start, cu_addr_a, cu_addr_b, cu_addr_out, cu_len  out  1/ADDR_WIDTH x3/32  drive the vector-add compute unit.
REQ-011 cu_done  in  1  single-cycle completion pulse from the compute unit.
REQ-012 bram_addr_a, bram_din_a, bram_dout_a, bram_en_a, bram_we_a  out/out/in/out/out  ADDR_WIDTH/DATA_WIDTH/DATA_WIDTH/1/1  BRAM port A; read latency is 1 cycle.
REQ-013 busy  out  1  high whenever the state is not IDLE.

Function
REQ-014 States SHALL be IDLE, LOAD_A, LOAD_B, START, WAIT_DONE, RD_ISSUE, RD_WAIT, RD_CAPT and SEND.
REQ-015 cmd_ready SHALL be high only in IDLE; on a command handshake, base addresses and len are latched, idx=0, and the next state is LOAD_A.
REQ-016 If the latched len==0, the block SHALL return to IDLE the next cycle: no BRAM access, no cu_start, no m_valid.
REQ-017 s_ready SHALL be high only in LOAD_A and LOAD_B.
REQ-018 Each stream handshake in LOAD_A SHALL register a BRAM write (en=we=1, addr=addr_a+idx, din=s_data) visible the following cycle.
REQ-019 LOAD_B SHALL behave as LOAD_A but with base addr_b.
REQ-020 idx SHALL increment on each stream handshake; on the handshake with idx==len-1, idx resets to 0 and the state advances (LOAD_A->LOAD_B->START).
REQ-021 All address sums SHALL be truncated to ADDR_WIDTH, wrapping modulo 2^ADDR_WIDTH.
REQ-022 bram_en_a and bram_we_a SHALL default low in every cycle without a registered access.
REQ-023 cu_addr_* and cu_len SHALL present the latched command values continuously from acceptance until the block returns to IDLE.
REQ-024 START SHALL assert cu_start for exactly one cycle, then go to WAIT_DONE.
REQ-025 WAIT_DONE SHALL hold until cu_done=1, then go to RD_ISSUE with idx=0.
REQ-026 cu_done in any state other than WAIT_DONE SHALL be ignored.
REQ-027 RD_ISSUE SHALL register a read (en=1, we=0, addr=addr_out+idx) and go to RD_WAIT.
REQ-028 RD_WAIT SHALL last one cycle and go to RD_CAPT.
REQ-029 RD_CAPT SHALL load m_data from bram_dout_a, set m_valid=1, set m_last=(idx==len-1), and go to SEND.
REQ-030 In SEND, m_data and m_last SHALL hold stable while m_valid=1 and m_ready=0.
REQ-031 On m_ready=1 in SEND, m_valid SHALL drop; if the word was the last, the next state is IDLE, otherwise idx increments and the next state is RD_ISSUE.
REQ-032 Minimum throughput SHALL be one result word per 4 cycles.
REQ-033 Port A read and write SHALL never be issued in the same cycle.

Reset
REQ-034 While rst=1, at the next edge: state=IDLE; idx=0.
REQ-035 While rst=1, at the next edge: all latched command registers=0; cmd_ready=0; s_ready=0; m_valid=0; m_last=0; m_data=0.
REQ-036 While rst=1, at the next edge: cu_start=0; bram_en_a=0; bram_we_a=0; bram_addr_a=0; bram_din_a=0; busy=0.
REQ-037 cmd_ready SHALL rise in the first cycle after rst deasserts.
REQ-038 A reset mid-operation SHALL abandon the command with no further BRAM writes, cu_start or stream output; partial BRAM contents are undefined.

Structure
REQ-039 The state enum and the BRAM read-latency constant (1) SHALL live in a shared package, vadd_pkg.
REQ-040 One sub-module, stream_out_reg, SHALL hold m_data/m_valid/m_last and the hold-under-backpressure logic; the FSM SHALL stay in the top module.

Verification
REQ-041 len=4, A=1..4 at 0x000, B=10..40 at 0x100, out 0x200, compute model sums, m_ready=1 -> BRAM writes 8 words; one cu_start pulse; m_data=11,22,33,44; m_last on the 4th word only.
REQ-042 len=0 command -> cmd_ready returns high 1 cycle later; no BRAM enable, cu_start or m_valid.
REQ-043 len=3, s_valid toggled 1/0 and m_ready high every 3rd cycle -> no lost or duplicated word; m_data stable while stalled.
REQ-044 addr_a=0x1FFE, len=3 -> writes to 0x1FFE, 0x1FFF, 0x0000.
REQ-045 Spurious cu_done during LOAD_A, then rst asserted during WAIT_DONE -> spurious pulse ignored; after reset every output is at reset value and the next command completes correctly.
